conv2d_gather_reader: RTL and testbench

CONV2D_GATHER_READER -- requirements
Module: conv2d_gather_reader

---
 rtl/conv2d_gather_reader_if.sv | 60 ++++++
 rtl/conv2d_gather_reader.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_conv2d_gather_reader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_gather_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_gather_reader_if
//  Description : Control, read-request and output-stream signals of the
//                2-D convolution gather reader, bundled with master (reader)
//                and slave (memory / consumer side) modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv2d_gather_reader_if #(
    parameter int AW = 16
);
    logic                 start;
    logic                 rd_req;
    logic                 rd_ack;
    logic [AW-1:0]        rd_addr_in;
    logic [AW-1:0]        rd_addr_w;
    logic                 valid_in;
    logic signed [15:0]   input_data;
    logic signed [15:0]   weight_data;
    logic                 valid_out;
    logic                 ready_out;
    logic signed [31:0]   output_data;
    logic                 busy;
    logic                 done;

    // Reader side: issues reads, produces the output stream.
    modport master (
        input  start,
        output rd_req,
        input  rd_ack,
        output rd_addr_in,
        output rd_addr_w,
        input  valid_in,
        input  input_data,
        input  weight_data,
        output valid_out,
        input  ready_out,
        output output_data,
        output busy,
        output done
    );

    // Environment side: memory responder and output consumer.
    modport slave (
        output start,
        input  rd_req,
        output rd_ack,
        input  rd_addr_in,
        input  rd_addr_w,
        output valid_in,
        output input_data,
        output weight_data,
        input  valid_out,
        output ready_out,
        input  output_data,
        input  busy,
        input  done
    );
endinterface : conv2d_gather_reader_if
`default_nettype wire

// File: rtl/conv2d_gather_reader.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_gather_reader
//  Description : Sequential grouped/dilated/strided/padded 2-D convolution.
//                Walks outputs in (oc, oh, ow) order and, per output, taps in
//                (ci_local, kh, kw) order. Each in-bounds tap fetches one
//                input sample and one weight through a single-outstanding
//                request/response port and accumulates the product into a
//                40-bit signed accumulator. Out-of-bounds (pad) taps cost one
//                cycle and issue no read.
//  Options     : CONV2D_GATHER_SAT_EN - when defined, output_data saturates
//                the accumulator to 32-bit signed; otherwise it wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_gather_reader #(
    parameter int IN_H   = 3,
    parameter int IN_W   = 3,
    parameter int C_IN   = 2,
    parameter int C_OUT  = 2,
    parameter int GROUPS = 2,
    parameter int KH     = 2,
    parameter int KW     = 2,
    parameter int SH     = 1,
    parameter int SW     = 1,
    parameter int PH     = 0,
    parameter int PW     = 0,
    parameter int DH     = 1,
    parameter int DW     = 1,
    parameter int AW     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    conv2d_gather_reader_if.master bus
);

    localparam int c_CPG = C_IN / GROUPS;
    localparam int c_OPG = C_OUT / GROUPS;
    localparam int c_OH  = (IN_H + 2 * PH - DH * (KH - 1) - 1) / SH + 1;
    localparam int c_OW  = (IN_W + 2 * PW - DW * (KW - 1) - 1) / SW + 1;

    localparam logic signed [39:0] c_SAT_MAX = 40'sd2147483647;
    localparam logic signed [39:0] c_SAT_MIN = -40'sd2147483648;

    // Channels must split evenly across groups; anything else is rejected.
    generate
        if (((C_IN % GROUPS) != 0) || ((C_OUT % GROUPS) != 0)) begin : g_bad_groups
            $error("conv2d_gather_reader: C_IN and C_OUT must be multiples of GROUPS");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAP  = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_EMIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;

    // Output position and tap position counters.
    int                  oc_q,  oc_d;
    int                  oh_q,  oh_d;
    int                  ow_q,  ow_d;
    int                  cil_q, cil_d;
    int                  kh_q,  kh_d;
    int                  kw_q,  kw_d;

    logic signed [39:0]  acc_q, acc_d;
    logic [AW-1:0]       addr_in_q, addr_in_d;
    logic [AW-1:0]       addr_w_q,  addr_w_d;

    // Tap geometry for the current counters.
    int                  w_grp;
    int                  w_ci;
    int                  w_ih;
    int                  w_iw;
    int                  w_addr_in;
    int                  w_addr_w;
    logic                w_pad;
    logic                w_last_tap;
    logic                w_last_out;

    // Successor positions.
    int                  w_kw_nxt, w_kh_nxt, w_cil_nxt;
    int                  w_ow_nxt, w_oh_nxt, w_oc_nxt;

    logic signed [31:0]  w_prod;
    logic signed [39:0]  w_prod_ext;
    logic signed [31:0]  w_out_data;

    logic                w_rd_req;
    logic                w_valid_out;
    logic                w_done;

    // Signed tap coordinates and the addresses they map to.
    always_comb begin
        w_grp      = oc_q / c_OPG;
        w_ci       = w_grp * c_CPG + cil_q;
        w_ih       = oh_q * SH - PH + kh_q * DH;
        w_iw       = ow_q * SW - PW + kw_q * DW;
        w_pad      = (w_ih < 0) || (w_ih > IN_H - 1) || (w_iw < 0) || (w_iw > IN_W - 1);
        w_addr_in  = (w_ci * IN_H + w_ih) * IN_W + w_iw;
        w_addr_w   = ((oc_q * c_CPG + cil_q) * KH + kh_q) * KW + kw_q;
        w_last_tap = (cil_q == c_CPG - 1) && (kh_q == KH - 1) && (kw_q == KW - 1);
        w_last_out = (oc_q == C_OUT - 1) && (oh_q == c_OH - 1) && (ow_q == c_OW - 1);
    end

    // Next tap in (ci_local, kh, kw) order, wrapping to the first tap.
    always_comb begin
        w_kw_nxt  = kw_q + 1;
        w_kh_nxt  = kh_q;
        w_cil_nxt = cil_q;
        if (kw_q == KW - 1) begin
            w_kw_nxt = 0;
            w_kh_nxt = kh_q + 1;
            if (kh_q == KH - 1) begin
                w_kh_nxt  = 0;
                w_cil_nxt = (cil_q == c_CPG - 1) ? 0 : cil_q + 1;
            end
        end
    end

    // Next output position in (oc, oh, ow) order.
    always_comb begin
        w_ow_nxt = ow_q + 1;
        w_oh_nxt = oh_q;
        w_oc_nxt = oc_q;
        if (ow_q == c_OW - 1) begin
            w_ow_nxt = 0;
            w_oh_nxt = oh_q + 1;
            if (oh_q == c_OH - 1) begin
                w_oh_nxt = 0;
                w_oc_nxt = (oc_q == C_OUT - 1) ? 0 : oc_q + 1;
            end
        end
    end

    // Full-precision signed product, sign-extended to accumulator width.
    always_comb begin
        w_prod     = 32'(bus.input_data) * 32'(bus.weight_data);
        w_prod_ext = {{8{w_prod[31]}}, w_prod};
    end

    // Accumulator to 32-bit output: saturate or wrap depending on build.
    always_comb begin
`ifdef CONV2D_GATHER_SAT_EN
        if (acc_q > c_SAT_MAX) begin
            w_out_data = 32'sh7FFFFFFF;
        end else if (acc_q < c_SAT_MIN) begin
            w_out_data = 32'sh80000000;
        end else begin
            w_out_data = acc_q[31:0];
        end
`else
        w_out_data = acc_q[31:0];
`endif
    end

    // Next-state, counter, accumulator and handshake decode.
    always_comb begin
        state_d     = state_q;
        oc_d        = oc_q;
        oh_d        = oh_q;
        ow_d        = ow_q;
        cil_d       = cil_q;
        kh_d        = kh_q;
        kw_d        = kw_q;
        acc_d       = acc_q;
        addr_in_d   = addr_in_q;
        addr_w_d    = addr_w_q;
        w_rd_req    = 1'b0;
        w_valid_out = 1'b0;
        w_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    oc_d    = 0;
                    oh_d    = 0;
                    ow_d    = 0;
                    cil_d   = 0;
                    kh_d    = 0;
                    kw_d    = 0;
                    acc_d   = '0;
                    state_d = S_TAP;
                end
            end

            S_TAP: begin
                if (w_pad) begin
                    // Pad tap contributes zero and just moves on.
                    cil_d   = w_cil_nxt;
                    kh_d    = w_kh_nxt;
                    kw_d    = w_kw_nxt;
                    state_d = w_last_tap ? S_EMIT : S_TAP;
                end else begin
                    // Latch addresses so they stay stable for the whole request.
                    addr_in_d = AW'(w_addr_in);
                    addr_w_d  = AW'(w_addr_w);
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                w_rd_req = 1'b1;
                if (bus.rd_ack) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.valid_in) begin
                    acc_d   = acc_q + w_prod_ext;
                    cil_d   = w_cil_nxt;
                    kh_d    = w_kh_nxt;
                    kw_d    = w_kw_nxt;
                    state_d = w_last_tap ? S_EMIT : S_TAP;
                end
            end

            S_EMIT: begin
                w_valid_out = 1'b1;
                if (bus.ready_out) begin
                    if (w_last_out) begin
                        state_d = S_DONE;
                    end else begin
                        oc_d    = w_oc_nxt;
                        oh_d    = w_oh_nxt;
                        ow_d    = w_ow_nxt;
                        acc_d   = '0;
                        state_d = S_TAP;
                    end
                end
            end

            S_DONE: begin
                w_done  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, accumulator and latched addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            oc_q      <= 0;
            oh_q      <= 0;
            ow_q      <= 0;
            cil_q     <= 0;
            kh_q      <= 0;
            kw_q      <= 0;
            acc_q     <= '0;
            addr_in_q <= '0;
            addr_w_q  <= '0;
        end else begin
            state_q   <= state_d;
            oc_q      <= oc_d;
            oh_q      <= oh_d;
            ow_q      <= ow_d;
            cil_q     <= cil_d;
            kh_q      <= kh_d;
            kw_q      <= kw_d;
            acc_q     <= acc_d;
            addr_in_q <= addr_in_d;
            addr_w_q  <= addr_w_d;
        end
    end

    assign bus.rd_req      = w_rd_req;
    assign bus.rd_addr_in  = addr_in_q;
    assign bus.rd_addr_w   = addr_w_q;
    assign bus.valid_out   = w_valid_out;
    assign bus.output_data = w_out_data;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = w_done;

endmodule : conv2d_gather_reader
`default_nettype wire

// File: tb/tb_conv2d_gather_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv2d_gather_reader
//  Description : Directed self-checking bench. One default-parameter reader
//                and one padded (PH=PW=1) reader share the memory/consumer
//                stimulus; a select picks which one is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_gather_reader;

`ifdef CONV2D_GATHER_SAT_EN
    localparam logic [31:0] c_SAT_EXP = 32'h7FFFFFFF;
`else
    localparam logic [31:0] c_SAT_EXP = 32'hFFFC0004;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_a = 1'b0;
    logic               start_p = 1'b0;
    logic               rd_ack = 1'b0;
    logic               valid_in = 1'b0;
    logic               ready_out = 1'b0;
    logic signed [15:0] din = 16'sd0;
    logic signed [15:0] wdin = 16'sd0;
    logic               sel = 1'b0;

    int                 checks = 0;
    int                 errors = 0;

    // Pass bookkeeping.
    logic [31:0]        out_log [0:63];
    int                 out_cnt, req_cnt, req_first, grp_bad, done_cnt;
    int                 hold_bad, stall_req, busy_bad, first_oc1_in, first_oc1_w;
    logic               done_seen;

    conv2d_gather_reader_if #(.AW(16)) ifa ();
    conv2d_gather_reader_if #(.AW(16)) ifp ();

    assign ifa.start       = start_a;
    assign ifa.rd_ack      = rd_ack;
    assign ifa.valid_in    = valid_in;
    assign ifa.input_data  = din;
    assign ifa.weight_data = wdin;
    assign ifa.ready_out   = ready_out;
    assign ifp.start       = start_p;
    assign ifp.rd_ack      = rd_ack;
    assign ifp.valid_in    = valid_in;
    assign ifp.input_data  = din;
    assign ifp.weight_data = wdin;
    assign ifp.ready_out   = ready_out;

    conv2d_gather_reader dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    conv2d_gather_reader #(.PH(1), .PW(1)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (ifp.master)
    );

    logic        w_rd_req, w_valid_out, w_busy, w_done;
    logic [15:0] w_addr_in, w_addr_w;
    logic [31:0] w_data;

    assign w_rd_req    = sel ? ifp.rd_req      : ifa.rd_req;
    assign w_valid_out = sel ? ifp.valid_out   : ifa.valid_out;
    assign w_busy      = sel ? ifp.busy        : ifa.busy;
    assign w_done      = sel ? ifp.done        : ifa.done;
    assign w_addr_in   = sel ? ifp.rd_addr_in  : ifa.rd_addr_in;
    assign w_addr_w    = sel ? ifp.rd_addr_w   : ifa.rd_addr_w;
    assign w_data      = sel ? ifp.output_data : ifa.output_data;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_req"},  64'(w_rd_req),    64'd0);
        chk({tag, "_valid"},   64'(w_valid_out), 64'd0);
        chk({tag, "_busy"},    64'(w_busy),      64'd0);
        chk({tag, "_done"},    64'(w_done),      64'd0);
        chk({tag, "_data"},    64'(w_data),      64'd0);
        chk({tag, "_addr_in"}, 64'(w_addr_in),   64'd0);
        chk({tag, "_addr_w"},  64'(w_addr_w),    64'd0);
    endtask

    // Runs one full pass: acks every request, answers one cycle after the
    // ack, optionally stalls the first output and pulses start while busy.
    task automatic run_pass(input logic use_p, input int stall, input logic extra_start, input int budget);
        logic        pending;
        int          stall_left;
        int          post;
        logic [31:0] cap;
        pending = 1'b0; stall_left = stall; post = 0; cap = '0;
        sel = use_p; out_cnt = 0; req_cnt = 0; req_first = -1; grp_bad = 0; done_cnt = 0;
        hold_bad = 0; stall_req = 0; busy_bad = 0; first_oc1_in = -1; first_oc1_w = -1;
        done_seen = 1'b0;
        @(negedge clk);
        if (use_p) start_p = 1'b1; else start_a = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_p = 1'b0;
            if (extra_start && cyc == 3) begin
                if (use_p) start_p = 1'b1; else start_a = 1'b1;
            end
            valid_in = pending;
            pending  = 1'b0;
            if (!done_seen && !w_busy) busy_bad++;
            if (w_rd_req) begin
                rd_ack  = 1'b1;
                pending = 1'b1;
                req_cnt++;
                if (!use_p && out_cnt >= 4) begin
                    if (first_oc1_in < 0) begin
                        first_oc1_in = int'(w_addr_in);
                        first_oc1_w  = int'(w_addr_w);
                    end
                    if (w_addr_in < 16'd9 || w_addr_in > 16'd17 || w_addr_w < 16'd4 || w_addr_w > 16'd7)
                        grp_bad++;
                end
            end else begin
                rd_ack = 1'b0;
            end
            if (w_valid_out) begin
                if (stall_left > 0) begin
                    ready_out = 1'b0;
                    if (stall_left == stall) cap = w_data;
                    else if (w_data !== cap) hold_bad++;
                    if (w_rd_req) stall_req++;
                    stall_left--;
                end else begin
                    ready_out = 1'b1;
                    if (out_cnt == 0) req_first = req_cnt;
                    if (out_cnt < 64) out_log[out_cnt] = w_data;
                    out_cnt++;
                end
            end else begin
                ready_out = 1'b0;
                if (stall_left > 0 && stall_left < stall) hold_bad++;
            end
            if (w_done) begin
                done_cnt++;
                done_seen = 1'b1;
            end else if (done_seen) begin
                post++;
                if (post == 3) break;
            end
        end
        rd_ack = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
        chk("pass_completed", 64'(done_seen), 64'd1);
        chk("idle_after_pass", 64'(w_busy), 64'd0);
    endtask

    task automatic wait_req(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (w_rd_req) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Serves reads without consuming output, stopping at the first EMIT.
    task automatic serve_until_valid(input int budget, output logic found);
        logic pending;
        pending = 1'b0;
        found   = 1'b0;
        ready_out = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start_a  = 1'b0;
            valid_in = pending;
            pending  = 1'b0;
            if (w_valid_out) begin
                rd_ack = 1'b0;
                found  = 1'b1;
                break;
            end
            if (w_rd_req) begin
                rd_ack  = 1'b1;
                pending = 1'b1;
            end else begin
                rd_ack = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1; rd_ack = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
        start_a = 1'b0; start_p = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic found;
        int   sum;

        // Power-on reset.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        chk_reset_outputs("por_a");
        sel = 1'b1;
        chk_reset_outputs("por_p");

        // Default geometry, all ones, first output stalled 5 cycles,
        // extra start while busy.
        din = 16'sd1; wdin = 16'sd1;
        run_pass(1'b0, 5, 1'b1, 2000);
        chk("dflt_out_cnt", 64'(out_cnt), 64'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("dflt_out%0d", i), 64'(out_log[i]), 64'd4);
        chk("dflt_done_cnt", 64'(done_cnt), 64'd1);
        chk("dflt_req_cnt", 64'(req_cnt), 64'd32);
        chk("stall_hold", 64'(hold_bad), 64'd0);
        chk("stall_no_req", 64'(stall_req), 64'd0);
        chk("dflt_busy", 64'(busy_bad), 64'd0);
        chk("grp_range", 64'(grp_bad), 64'd0);
        chk("grp_first_in", 64'(first_oc1_in), 64'd9);
        chk("grp_first_w", 64'(first_oc1_w), 64'd4);

        // Padded geometry, all ones.
        run_pass(1'b1, 0, 1'b0, 4000);
        chk("pad_out_cnt", 64'(out_cnt), 64'd32);
        chk("pad_out000", 64'(out_log[0]), 64'd1);
        chk("pad_req_first", 64'(req_first), 64'd1);
        chk("pad_out011", 64'(out_log[5]), 64'd4);
        chk("pad_req_cnt", 64'(req_cnt), 64'd72);
        sum = 0;
        for (int i = 0; i < 32; i++) sum += int'(out_log[i]);
        chk("pad_sum", 64'(sum), 64'd72);
        chk("pad_done_cnt", 64'(done_cnt), 64'd1);

        // Saturation / wrap with full-scale positive operands.
        din = 16'sh7FFF; wdin = 16'sh7FFF;
        run_pass(1'b0, 0, 1'b0, 2000);
        chk("sat_out0", 64'(out_log[0]), 64'(c_SAT_EXP));
        chk("sat_out7", 64'(out_log[7]), 64'(c_SAT_EXP));

        // Reset in the middle of a request, then a stray response.
        din = 16'sd1; wdin = 16'sd1; sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        wait_req(20, found);
        chk("rq_found", 64'(found), 64'd1);
        pulse_reset();
        chk_reset_outputs("rst_req");
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        chk("stray_resp_busy", 64'(w_busy), 64'd0);
        chk("stray_resp_data", 64'(w_data), 64'd0);

        // Restart goes back to the first tap, then reset during EMIT.
        start_a = 1'b1;
        wait_req(20, found);
        chk("restart1_found", 64'(found), 64'd1);
        chk("restart1_addr_in", 64'(w_addr_in), 64'd0);
        chk("restart1_addr_w", 64'(w_addr_w), 64'd0);
        serve_until_valid(100, found);
        chk("emit_found", 64'(found), 64'd1);
        chk("emit_data", 64'(w_data), 64'd4);
        pulse_reset();
        chk_reset_outputs("rst_emit");
        start_a = 1'b1;
        wait_req(20, found);
        chk("restart2_found", 64'(found), 64'd1);
        chk("restart2_addr_in", 64'(w_addr_in), 64'd0);
        chk("restart2_addr_w", 64'(w_addr_w), 64'd0);
        pulse_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_conv2d_gather_reader
`default_nettype wire
